// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator result path.
// Holds ALU op codes, FSM encoding, 7-segment codes and small helpers.
// Imported by result_display and bin2bcd_seq.
package calc_pkg;

  // ALU operation one-hot codes
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0001;
  localparam logic [3:0] OP_STOP = 4'b0000;

  // Conversion FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Active-low segment codes, bit 0 = a ... bit 6 = g, bit 7 = dp
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Raw ALU result as sampled on a capture event
  typedef struct packed {
    logic [7:0] res;
    logic       sgn;
  } capt_t;

  // Three BCD digits, hundreds in the top nibble
  typedef struct packed {
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] one;
  } bcd_t;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // A negative signed result is shown as its magnitude; -128 maps to 128
  function automatic logic neg_of(input capt_t c);
    return c.sgn & c.res[7];
  endfunction

  function automatic logic [7:0] mag_of(input capt_t c);
    if (neg_of(c)) return ~c.res + 8'd1;
    return c.res;
  endfunction

endpackage

// File: rtl/result_display_if.sv
// ALU-to-display bundle: capture request and result in, status and display drive out.
// No internal latency; plain wires.
// The display side has no backpressure: captures are always accepted or buffered.
interface result_display_if;
  logic       alu_busy;
  logic       res_valid;
  logic [7:0] res;
  logic       signed_in;
  logic       conv_busy;
  logic [3:0] an;
  logic [7:0] seg;

  modport master (
    output alu_busy, res_valid, res, signed_in,
    input  conv_busy, an, seg
  );

  modport slave (
    input  alu_busy, res_valid, res, signed_in,
    output conv_busy, an, seg
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to 3 BCD digits, one shift per cycle.
// Latency: 8 cycles after start; done pulses during the last shift cycle.
// No backpressure: a start while running restarts the conversion.
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output bcd_t       bcd
);

  logic [11:0] bcd_q;
  logic [7:0]  bin_q;
  logic [2:0]  cnt_q;
  logic        run_q;
  logic [11:0] adj;

  // Add 3 to every nibble >= 5 before it is shifted
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // Load on start, otherwise shift {bcd, bin} left once per cycle for 8 cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= 3'd0;
      bcd_q <= 12'd0;
      bin_q <= 8'd0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= 3'd0;
      bcd_q <= 12'd0;
      bin_q <= bin;
    end else if (run_q) begin
      {bcd_q, bin_q} <= {adj[10:0], bin_q, 1'b0};
      cnt_q          <= cnt_q + 3'd1;
      if (cnt_q == 3'd7) run_q <= 1'b0;
    end
  end

  assign done = run_q && (cnt_q == 3'd7);
  assign bcd  = bcd_q;

endmodule

// File: rtl/result_display.sv
// Captures ALU results, converts them to BCD and scans a 4-digit active-low 7-seg display.
// Latency: capture in cycle N, display regs updated from N+10, pins one cycle later.
// No backpressure: captures during a conversion are buffered, most recent wins.
module result_display
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic             clk,
  input logic             rst,
  result_display_if.slave bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic          busy_d;
  logic          capture;
  capt_t         cur_c;
  capt_t         pend_buf_q;
  capt_t         start_src;
  logic          pend_q;
  logic          start;
  logic          conv_done;
  logic          neg_q;
  logic          disp_neg_q;
  logic [1:0]    state_q;
  bcd_t          conv_bcd;
  bcd_t          disp_q;
  logic [7:0]    start_mag;

  logic [CW-1:0] scan_cnt_q;
  logic [1:0]    scan_idx_q;
  logic [1:0]    scan_idx_nxt;
  logic          scan_wrap;
  logic [3:0]    an_nxt;
  logic [7:0]    seg_nxt;
  logic [3:0]    an_q;
  logic [7:0]    seg_q;

  assign cur_c   = {bus.res, bus.signed_in};
  assign capture = (busy_d & ~bus.alu_busy) | bus.res_valid;

  // Register alu_busy so its falling edge can be detected
  always_ff @(posedge clk) begin
    if (rst) busy_d <= 1'b0;
    else     busy_d <= bus.alu_busy;
  end

  // Launch a conversion from IDLE on capture, or from DONE with the newest queued value
  always_comb begin
    start     = 1'b0;
    start_src = cur_c;
    if (state_q == ST_IDLE && capture) begin
      start = 1'b1;
    end else if (state_q == ST_DONE && (capture || pend_q)) begin
      start     = 1'b1;
      start_src = capture ? cur_c : pend_buf_q;
    end
  end

  assign start_mag = mag_of(start_src);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (start_mag),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Conversion FSM, pending buffer and display registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      pend_buf_q <= '0;
      neg_q      <= 1'b0;
      disp_q     <= '0;
      disp_neg_q <= 1'b0;
    end else begin
      if (start) neg_q <= neg_of(start_src);
      case (state_q)
        ST_IDLE: begin
          if (capture) state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (capture) begin
            pend_q     <= 1'b1;
            pend_buf_q <= cur_c;
          end
          if (conv_done) state_q <= ST_DONE;
        end
        ST_DONE: begin
          disp_q     <= conv_bcd;
          disp_neg_q <= neg_q;
          pend_q     <= 1'b0;
          state_q    <= start ? ST_SHIFT : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.conv_busy = (state_q != ST_IDLE);

  // Free-running scan: hold each digit for SCAN_DIV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      scan_idx_q <= 2'd0;
    end else begin
      scan_cnt_q <= scan_wrap ? '0 : scan_cnt_q + 1'b1;
      scan_idx_q <= scan_idx_nxt;
    end
  end

  assign scan_wrap    = (scan_cnt_q == CW'(SCAN_DIV - 1));
  assign scan_idx_nxt = scan_wrap ? scan_idx_q + 2'd1 : scan_idx_q;

  // Select digit and segment pattern for the next scan position
  always_comb begin
    an_nxt  = 4'b1110;
    seg_nxt = seg_code(disp_q.one);
    case (scan_idx_nxt)
      2'd0: begin
        an_nxt  = 4'b1110;
        seg_nxt = seg_code(disp_q.one);
      end
      2'd1: begin
        an_nxt  = 4'b1101;
        seg_nxt = (BLANK_LZ && disp_q.hun == 4'd0 && disp_q.ten == 4'd0) ? SEG_BLANK
                                                                         : seg_code(disp_q.ten);
      end
      2'd2: begin
        an_nxt  = 4'b1011;
        seg_nxt = (BLANK_LZ && disp_q.hun == 4'd0) ? SEG_BLANK : seg_code(disp_q.hun);
      end
      default: begin
        an_nxt  = 4'b0111;
        seg_nxt = disp_neg_q ? SEG_MINUS : SEG_BLANK;
      end
    endcase
  end

  // an and seg share one register stage so they always switch together
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= 4'b1110;
      seg_q <= SEG_0;
    end else begin
      an_q  <= an_nxt;
      seg_q <= seg_nxt;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;

endmodule

// File: tb/tb_result_display.sv
// Randomised and directed bench for result_display with SCAN_DIV=4.
// Reference model works from decimal arithmetic on the captured value.
// Drives inputs #1 after posedge, samples on negedge.
module tb_result_display;

  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // Value currently expected on the display
  logic [7:0] disp_v = 8'd0;
  logic       disp_s = 1'b0;

  result_display_if bus_if ();

  result_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] digit_seg(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      default: return 8'h90;
    endcase
  endfunction

  // Expected segment pattern for the digit selected by an, given the shown value
  function automatic logic [7:0] model_seg(input logic [3:0] an_v, input logic [7:0] v, input logic s);
    int val, mag, h, t, o;
    bit neg;
    val = s ? int'($signed(v)) : int'(v);
    neg = (val < 0);
    mag = neg ? -val : val;
    h = mag / 100;
    t = (mag / 10) % 10;
    o = mag % 10;
    case (an_v)
      4'b1110: return digit_seg(o);
      4'b1101: return (h == 0 && t == 0) ? 8'hFF : digit_seg(t);
      4'b1011: return (h == 0) ? 8'hFF : digit_seg(h);
      4'b0111: return neg ? 8'hBF : 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit an_onecold(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
  endfunction

  // From the first cycle after reset: exact scan order, 4 cycles per digit
  task automatic check_rotation(input int ncyc);
    logic [3:0] exp_an;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << ((k / SD) % 4));
      chk("rot_an", bus_if.an, exp_an);
      chk("rot_seg", bus_if.seg, model_seg(exp_an, disp_v, disp_s));
      chk("rot_busy", bus_if.conv_busy, 1'b0);
    end
  endtask

  // Observe a full scan and compare every digit with the model
  task automatic check_scan(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      chk("an_onecold", an_onecold(bus_if.an), 1'b1);
      chk("scan_seg", bus_if.seg, model_seg(bus_if.an, disp_v, disp_s));
    end
  endtask

  // Issue one capture in cycle N; returns just after the edge that starts N+1
  task automatic capture(input logic [7:0] v, input logic s, input bit via_busy, input bit also_rv);
    if (via_busy) begin
      @(posedge clk); #1;
      bus_if.alu_busy = 1'b1;
    end
    @(posedge clk); #1;
    bus_if.alu_busy  = 1'b0;
    bus_if.res       = v;
    bus_if.signed_in = s;
    bus_if.res_valid = !via_busy || also_rv;
    @(posedge clk); #1;
    bus_if.res_valid = 1'b0;
  endtask

  // conv_busy must be high for exactly 9 cycles after the capture
  task automatic wait_conv(input logic [7:0] v, input logic s);
    int  n;
    bit  ended;
    n = 0;
    ended = 1'b0;
    for (int k = 0; k < 40 && !ended; k++) begin
      @(negedge clk);
      if (bus_if.conv_busy) n++;
      else ended = 1'b1;
    end
    chk("conv_ended", ended, 1'b1);
    chk("busy_len", n, 9);
    disp_v = v;
    disp_s = s;
  endtask

  typedef struct {
    logic [7:0] v;
    logic       s;
    bit         vb;
    bit         rv;
  } dir_t;

  initial begin
    dir_t dirs[8];
    logic [7:0] ev;
    logic [7:0] rv_val;
    logic       rs;
    bit         vb;

    dirs[0] = '{8'd255, 1'b0, 1'b0, 1'b1};
    dirs[1] = '{8'd12,  1'b0, 1'b1, 1'b1};
    dirs[2] = '{8'hF6,  1'b1, 1'b0, 1'b1};
    dirs[3] = '{8'h80,  1'b1, 1'b0, 1'b1};
    dirs[4] = '{8'd100, 1'b0, 1'b1, 1'b0};
    dirs[5] = '{8'hFF,  1'b1, 1'b0, 1'b1};
    dirs[6] = '{8'h7F,  1'b1, 1'b1, 1'b0};
    dirs[7] = '{8'd0,   1'b1, 1'b0, 1'b1};

    bus_if.alu_busy  = 1'b0;
    bus_if.res_valid = 1'b0;
    bus_if.res       = 8'd0;
    bus_if.signed_in = 1'b0;

    // Reset and idle scan
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_rotation(20);

    // Directed values, including busy-fall coinciding with res_valid
    foreach (dirs[i]) begin
      capture(dirs[i].v, dirs[i].s, dirs[i].vb, dirs[i].rv);
      wait_conv(dirs[i].v, dirs[i].s);
      check_scan(16);
    end

    // Back-to-back captures: 7, then 99 and 42 while converting
    @(posedge clk); #1;
    bus_if.res_valid = 1'b1;
    bus_if.res       = 8'd7;
    bus_if.signed_in = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      bus_if.res_valid = (c == 3) || (c == 6);
      if (c == 3) bus_if.res = 8'd99;
      if (c == 6) bus_if.res = 8'd42;
      @(negedge clk);
      chk("pend_busy", bus_if.conv_busy, (c <= 18));
      if (c <= 10)      ev = disp_v;
      else if (c <= 19) ev = 8'd7;
      else              ev = 8'd42;
      chk("pend_seg", bus_if.seg, model_seg(bus_if.an, ev, (c <= 10) ? disp_s : 1'b0));
    end
    disp_v = 8'd42;
    disp_s = 1'b0;

    // Reset in the middle of a conversion with a value pending
    capture(8'd200, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus_if.res_valid = 1'b1;
    bus_if.res       = 8'd55;
    @(posedge clk); #1;
    bus_if.res_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    disp_v = 8'd0;
    disp_s = 1'b0;
    check_rotation(20);
    capture(8'd33, 1'b0, 1'b0, 1'b1);
    wait_conv(8'd33, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("no_restart", bus_if.conv_busy, 1'b0);
    end
    check_scan(16);

    // Random captures through either request path
    for (int i = 0; i < 24; i++) begin
      rv_val = 8'($urandom_range(0, 255));
      rs     = 1'($urandom_range(0, 1));
      vb     = 1'($urandom_range(0, 1));
      capture(rv_val, rs, vb, 1'b0);
      wait_conv(rv_val, rs);
      check_scan(16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
